// File: rtl/set_point_tracker_if.sv
// Set-counter interface: per-team set increment/decrement pulses from the
// point tracker (producer) to the set counters (consumer).
interface set_point_tracker_if;
  logic set_inc_a;
  logic set_inc_b;
  logic set_dec_a;
  logic set_dec_b;

  modport master (output set_inc_a, output set_inc_b, output set_dec_a, output set_dec_b);
  modport slave  (input  set_inc_a, input  set_inc_b, input  set_dec_a, input  set_dec_b);
endinterface

// File: rtl/set_point_tracker.sv
// Volleyball set point tracker: rally scoring, set-win detection with a
// win-by-lead rule, multi-level undo through a circular LIFO of scorer IDs,
// and one-cycle pulses toward the per-team set counters.
module set_point_tracker #(
  parameter int TARGET        = 25,
  parameter int DECIDE_TARGET = 15,
  parameter int LEAD          = 2,
  parameter int SCORE_W       = 6,
  parameter int HIST_DEPTH    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pt_a,
  input  logic               pt_b,
  input  logic               undo,
  input  logic               next_set,
  input  logic               deciding_set,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b,
  output logic               serve,
  output logic               set_over,
  output logic               conflict,
  set_point_tracker_if.master set_cnt
);

  localparam int PTR_W = $clog2(HIST_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(HIST_DEPTH);
  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0]   PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W-1:0]   PTR_TWO = PTR_W'(2);
  localparam logic [SCORE_W:0]   TGT_C   = (SCORE_W+1)'(TARGET);
  localparam logic [SCORE_W:0]   DTGT_C  = (SCORE_W+1)'(DECIDE_TARGET);
  localparam logic [SCORE_W:0]   LEAD_C  = (SCORE_W+1)'(LEAD);
  localparam logic [SCORE_W-1:0] S_ONE   = SCORE_W'(1);

  typedef enum logic {PLAY, SET_OVER} state_t;

  state_t                state_q, state_d;
  logic [SCORE_W-1:0]    sa_q, sa_d, sb_q, sb_d;
  logic                  serve_q, serve_d;
  logic [HIST_DEPTH-1:0] hist_q, hist_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  inc_a_q, inc_a_d, inc_b_q, inc_b_d;
  logic                  dec_a_q, dec_a_d, dec_b_q, dec_b_d;
  logic                  conf_q, conf_d;

  logic                  pa_only, pb_only;
  logic                  do_pop, do_push, push_id;
  logic                  pop_top, prev_top;
  logic [SCORE_W:0]      next_a, next_b, tgt;

  // Win is evaluated one bit wider than the score so other+LEAD never wraps.
  function automatic logic wins(input logic [SCORE_W:0] me,
                                input logic [SCORE_W:0] other,
                                input logic [SCORE_W:0] t);
    return (me >= t) && (me >= other + LEAD_C);
  endfunction

  assign pa_only  = pt_a & ~pt_b;
  assign pb_only  = pt_b & ~pt_a;
  assign pop_top  = hist_q[ptr_q - PTR_ONE];
  assign prev_top = hist_q[ptr_q - PTR_TWO];
  assign next_a   = {1'b0, sa_q} + (SCORE_W+1)'(1);
  assign next_b   = {1'b0, sb_q} + (SCORE_W+1)'(1);
  assign tgt      = deciding_set ? DTGT_C : TGT_C;

  // Next-state, scoring, history and pulse generation.
  // Only the scoring team is checked for a win, so a deciding_set change can
  // never award a set to the team that did not just score.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    serve_d = serve_q;
    hist_d  = hist_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    inc_a_d = 1'b0;
    inc_b_d = 1'b0;
    dec_a_d = 1'b0;
    dec_b_d = 1'b0;
    conf_d  = pt_a & pt_b;
    do_pop  = 1'b0;
    do_push = 1'b0;
    push_id = 1'b0;

    unique case (state_q)
      PLAY: begin
        if (undo) begin
          do_pop = (cnt_q != '0);
        end else if (pa_only && (sa_q != '1)) begin
          sa_d    = next_a[SCORE_W-1:0];
          do_push = 1'b1;
          push_id = 1'b0;
          serve_d = 1'b0;
          if (wins(next_a, {1'b0, sb_q}, tgt)) begin
            inc_a_d = 1'b1;
            state_d = SET_OVER;
          end
        end else if (pb_only && (sb_q != '1)) begin
          sb_d    = next_b[SCORE_W-1:0];
          do_push = 1'b1;
          push_id = 1'b1;
          serve_d = 1'b1;
          if (wins(next_b, {1'b0, sa_q}, tgt)) begin
            inc_b_d = 1'b1;
            state_d = SET_OVER;
          end
        end
      end
      SET_OVER: begin
        if (undo) begin
          do_pop  = (cnt_q != '0);
          dec_a_d = do_pop & ~pop_top;
          dec_b_d = do_pop & pop_top;
          state_d = PLAY;
        end else if (next_set) begin
          sa_d    = '0;
          sb_d    = '0;
          ptr_d   = '0;
          cnt_d   = '0;
          state_d = PLAY;
        end
      end
      default: state_d = PLAY;
    endcase

    if (do_pop) begin
      ptr_d = ptr_q - PTR_ONE;
      cnt_d = cnt_q - CNT_ONE;
      if (pop_top) sb_d = sb_q - S_ONE;
      else         sa_d = sa_q - S_ONE;
      serve_d = (cnt_q > CNT_ONE) ? prev_top : 1'b0;
    end

    if (do_push) begin
      hist_d[ptr_q] = push_id;
      ptr_d         = ptr_q + PTR_ONE;
      if (cnt_q != DEPTH_C) cnt_d = cnt_q + CNT_ONE;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= PLAY;
      sa_q    <= '0;
      sb_q    <= '0;
      serve_q <= 1'b0;
      hist_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      inc_a_q <= 1'b0;
      inc_b_q <= 1'b0;
      dec_a_q <= 1'b0;
      dec_b_q <= 1'b0;
      conf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      serve_q <= serve_d;
      hist_q  <= hist_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      inc_a_q <= inc_a_d;
      inc_b_q <= inc_b_d;
      dec_a_q <= dec_a_d;
      dec_b_q <= dec_b_d;
      conf_q  <= conf_d;
    end
  end

  assign score_a           = sa_q;
  assign score_b           = sb_q;
  assign serve             = serve_q;
  assign set_over          = (state_q == SET_OVER);
  assign conflict          = conf_q;
  assign set_cnt.set_inc_a = inc_a_q;
  assign set_cnt.set_inc_b = inc_b_q;
  assign set_cnt.set_dec_a = dec_a_q;
  assign set_cnt.set_dec_b = dec_b_q;

endmodule

// File: tb/tb_set_point_tracker.sv
// Testbench for set_point_tracker: directed scenarios followed by random
// rallies, all checked against a score/queue reference model.
module tb_set_point_tracker;

  localparam int SCORE_W = 6;
  localparam int MAXS    = (1 << SCORE_W) - 1;
  localparam int DEPTH   = 8;

  logic clk = 1'b0;
  logic rst, pt_a, pt_b, undo, next_set, deciding_set;
  logic [SCORE_W-1:0] score_a, score_b;
  logic serve, set_over, conflict;

  set_point_tracker_if sif ();

  set_point_tracker #(
    .TARGET(25), .DECIDE_TARGET(15), .LEAD(2), .SCORE_W(SCORE_W), .HIST_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .pt_a(pt_a), .pt_b(pt_b), .undo(undo),
    .next_set(next_set), .deciding_set(deciding_set),
    .score_a(score_a), .score_b(score_b), .serve(serve),
    .set_over(set_over), .conflict(conflict), .set_cnt(sif)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;

  // Reference model state
  int   m_sa, m_sb;
  bit   m_serve, m_over, m_conf;
  bit   m_hist[$];
  logic [3:0] m_pulse;   // {inc_a, inc_b, dec_a, dec_b}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sa = 0; m_sb = 0; m_serve = 0; m_over = 0; m_conf = 0;
    m_pulse = '0;
    m_hist.delete();
  endtask

  task automatic model_undo(output bit popped, output bit id);
    popped = 0; id = 0;
    if (m_hist.size() > 0) begin
      popped = 1;
      id = m_hist.pop_back();
      if (id) m_sb--; else m_sa--;
      m_serve = (m_hist.size() > 0) ? m_hist[$] : 1'b0;
    end
  endtask

  task automatic model_step(input bit pa, input bit pb, input bit u, input bit ns, input bit ds);
    int tgt;
    bit popped, id;
    tgt = ds ? 15 : 25;
    m_pulse = '0;
    m_conf = pa && pb;
    if (!m_over) begin
      if (u) begin
        model_undo(popped, id);
      end else if (pa && !pb) begin
        if (m_sa < MAXS) begin
          m_sa++;
          m_hist.push_back(1'b0);
          if (m_hist.size() > DEPTH) m_hist.delete(0);
          m_serve = 0;
          if (m_sa >= tgt && m_sa >= m_sb + 2) begin m_pulse[3] = 1; m_over = 1; end
        end
      end else if (pb && !pa) begin
        if (m_sb < MAXS) begin
          m_sb++;
          m_hist.push_back(1'b1);
          if (m_hist.size() > DEPTH) m_hist.delete(0);
          m_serve = 1;
          if (m_sb >= tgt && m_sb >= m_sa + 2) begin m_pulse[2] = 1; m_over = 1; end
        end
      end
    end else begin
      if (u) begin
        model_undo(popped, id);
        if (popped) begin
          if (id) m_pulse[0] = 1; else m_pulse[1] = 1;
        end
        m_over = 0;
      end else if (ns) begin
        m_sa = 0; m_sb = 0; m_over = 0;
        m_hist.delete();
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/score_a"},  32'(score_a),  32'(m_sa));
    check({tag, "/score_b"},  32'(score_b),  32'(m_sb));
    check({tag, "/serve"},    32'(serve),    32'(m_serve));
    check({tag, "/set_over"}, 32'(set_over), 32'(m_over));
    check({tag, "/conflict"}, 32'(conflict), 32'(m_conf));
    check({tag, "/pulses"},
          32'({sif.set_inc_a, sif.set_inc_b, sif.set_dec_a, sif.set_dec_b}), 32'(m_pulse));
  endtask

  // Apply one cycle of pulses, advance one edge, compare 1 time unit later.
  task automatic step(input string tag, input bit pa, input bit pb, input bit u, input bit ns);
    pt_a = pa; pt_b = pb; undo = u; next_set = ns;
    model_step(pa, pb, u, ns, deciding_set);
    @(posedge clk);
    #1;
    pt_a = 0; pt_b = 0; undo = 0; next_set = 0;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1;
  endtask

  initial begin
    rst = 0; pt_a = 0; pt_b = 0; undo = 0; next_set = 0; deciding_set = 0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check_all("reset");
    rst = 1;

    // Regular set: 25 straight points for A
    for (int i = 0; i < 25; i++) step("reg", 1, 0, 0, 0);
    check("reg/inc_a_final", 32'(sif.set_inc_a), 32'd1);
    step("reg_ignore_b", 0, 1, 0, 0);
    step("reg_ns_undo", 0, 0, 1, 1);   // undo beats next_set
    step("reg_rewin", 1, 0, 0, 0);
    step("reg_next", 0, 0, 0, 1);

    // Deuce
    for (int i = 0; i < 24; i++) begin
      step("deuce_a", 1, 0, 0, 0);
      step("deuce_b", 0, 1, 0, 0);
    end
    step("deuce_25_24", 1, 0, 0, 0);
    step("deuce_25_25", 0, 1, 0, 0);
    step("deuce_26_25", 1, 0, 0, 0);
    step("deuce_27_25", 1, 0, 0, 0);
    check("deuce/win_score", 32'(score_a), 32'd27);
    step("deuce_next", 0, 0, 0, 1);

    // Deciding set
    deciding_set = 1;
    for (int i = 0; i < 15; i++) step("decide", 0, 1, 0, 0);
    step("decide_next", 0, 0, 0, 1);
    deciding_set = 0;

    // Undo the winning point
    for (int i = 0; i < 10; i++) step("uw_b", 0, 1, 0, 0);
    for (int i = 0; i < 25; i++) step("uw_a", 1, 0, 0, 0);
    step("uw_undo", 0, 0, 1, 0);
    step("uw_pt_b", 0, 1, 0, 0);
    check("uw/serve", 32'(serve), 32'd1);
    do_reset();
    check_all("uw_reset");

    // History depth limit and empty-history undo
    for (int i = 0; i < 5; i++) begin
      step("hist_a", 1, 0, 0, 0);
      step("hist_b", 0, 1, 0, 0);
    end
    for (int i = 0; i < 10; i++) step("hist_undo", 0, 0, 1, 0);
    check("hist/score_a_floor", 32'(score_a), 32'd1);
    check("hist/score_b_floor", 32'(score_b), 32'd1);
    do_reset();
    step("empty_undo", 0, 0, 1, 0);

    // Conflicts
    step("conf_pre", 1, 0, 0, 0);
    step("conf_both", 1, 1, 0, 0);
    step("conf_undo", 1, 1, 1, 0);
    step("undo_vs_pt", 0, 1, 0, 0);
    step("undo_vs_pt2", 1, 0, 1, 0);
    step("next_in_play", 0, 0, 0, 1);

    // Saturation at the score ceiling
    do_reset();
    for (int i = 0; i < MAXS - 1; i++) begin
      step("sat_a", 1, 0, 0, 0);
      step("sat_b", 0, 1, 0, 0);
    end
    step("sat_a_max", 1, 0, 0, 0);
    step("sat_b_max", 0, 1, 0, 0);
    step("sat_a_drop", 1, 0, 0, 0);
    step("sat_b_drop", 0, 1, 0, 0);
    check("sat/score_a", 32'(score_a), 32'(MAXS));

    // Asynchronous reset at 20-18
    do_reset();
    for (int i = 0; i < 18; i++) begin
      step("ar_a", 1, 0, 0, 0);
      step("ar_b", 0, 1, 0, 0);
    end
    step("ar_a", 1, 0, 0, 0);
    step("ar_a", 1, 0, 0, 0);
    #2;
    rst = 0;
    model_reset();
    #1;
    check_all("async_reset");
    #1;
    rst = 1;
    @(posedge clk); #1;
    check_all("post_reset");

    // Random rallies
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 2) deciding_set = ~deciding_set;
      step("rand",
           $urandom_range(99) < 40,
           $urandom_range(99) < 40,
           $urandom_range(99) < 8,
           $urandom_range(99) < 15);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/set_point_tracker.md
Name: set_point_tracker

Overview:
- Tracks the rally points of both teams within one volleyball set.
- Detects a set win using a target score and a win-by-lead rule, with a separate target for the deciding set.
- Emits one-cycle increment and decrement pulses that drive the per-team set counters.
- Supports multi-level undo of points, including undoing the point that won a set. It is the producer side of the set-counter interface.

Parameters:
- TARGET, 25: points needed to win a regular set.
- DECIDE_TARGET, 15: points needed to win the deciding set.
- LEAD, 2: minimum winning margin.
- SCORE_W, 6: score width; scores saturate at 2^SCORE_W-1.
- HIST_DEPTH, 8: undo history depth in entries (power of 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- pt_a  in  1  one-cycle pulse: team A won a rally.
- pt_b  in  1  one-cycle pulse: team B won a rally.
- undo  in  1  one-cycle pulse: revert the most recent point.
- next_set  in  1  one-cycle pulse: start a new set after a set is over.
- deciding_set  in  1  level: use DECIDE_TARGET instead of TARGET.
- score_a  out  SCORE_W  team A points in the current set.
- score_b  out  SCORE_W  team B points in the current set.
- set_inc_a  out  1  one-cycle pulse: team A won the set.
- set_inc_b  out  1  one-cycle pulse: team B won the set.
- set_dec_a  out  1  one-cycle pulse: team A's set win was undone.
- set_dec_b  out  1  one-cycle pulse: team B's set win was undone.
- serve  out  1  serving team, 0 = A, 1 = B (winner of the last point).
- set_over  out  1  high while in the SET_OVER state.
- conflict  out  1  one-cycle pulse: pt_a and pt_b were both high in the same cycle.

Behaviour:
- Reset (rst low, async): all outputs go to 0, state is PLAY, history is empty (count 0).
- State PLAY:
  - A single point pulse increments that team's score on the sampling edge.
  - The scorer ID is pushed to the history; serve is set to the scorer.
- Win check uses the registered next-score values. tgt = deciding_set ? DECIDE_TARGET : TARGET. Team X wins when next_X >= tgt and next_X >= next_Y + LEAD. The comparison must be done in SCORE_W+1 bits so it cannot overflow.
- On a win, on the same edge:
  - the score shows the winning value;
  - set_inc_X goes high for exactly one cycle;
  - state becomes SET_OVER and set_over goes to 1.
- Point latency is one edge: a pulse sampled at edge N is visible on the outputs after edge N.
- State SET_OVER:
  - pt_a and pt_b are ignored, with no history push.
  - next_set clears both scores to 0, clears the history, returns to PLAY, and leaves serve unchanged.
  - undo pops the top entry (the winning point), decrements the winner's score, pulses set_dec_X for one cycle, and returns to PLAY.
- undo in PLAY:
  - With a non-empty history: pop the top entry and decrement that team's score.
  - serve becomes the new top entry, or 0 if the history is now empty.
  - With an empty history: no effect.
- History is a circular LIFO of 1-bit scorer IDs. When full, a push overwrites the oldest entry and the count stays at HIST_DEPTH, so undo depth is limited to HIST_DEPTH.
- Simultaneous events, in priority order:
  1. pt_a and pt_b together: neither point is taken, conflict pulses, and any undo or next_set in the same cycle is still processed.
  2. undo together with a single point: undo wins and the point is dropped.
  3. next_set in PLAY: ignored.
  4. next_set together with undo in SET_OVER: undo wins.
- Saturation: a point for a team already at 2^SCORE_W-1 is dropped, with no history push and no serve change.
- Changing deciding_set mid-set affects only subsequent win checks. It never retroactively triggers a win.
- Reset mid-set or in SET_OVER returns to the reset state immediately. No set_dec pulse is emitted.
- At most one of set_inc_a, set_inc_b, set_dec_a, set_dec_b is high in any cycle.

Test Plan:
- Regular set: 25 pt_a pulses with deciding_set=0 → score_a reaches 25 with set_inc_a high for exactly that cycle; set_over=1; further pt_b leaves score_b=0.
- Deuce: drive scores to 24-24, then pt_a (25-24, no win), pt_b (25-25), pt_a, pt_a → set_inc_a fires at 27-25 only.
- Deciding set: deciding_set=1, 15 pt_b pulses → set_inc_b fires at 0-15.
- Undo winning point: reach 25-10 so A wins, then undo → set_dec_a pulses, score 24-10, set_over=0. Then pt_b → 24-11 and serve=1.
- History limits:
  - 10 alternating points, then 10 undo pulses → only 8 points are reverted and the score stops at 1-1.
  - undo on an empty history changes nothing.
- Conflicts and reset:
  - pt_a and pt_b together → conflict pulse, scores unchanged.
  - undo with pt_a in the same cycle → only the undo takes effect.
  - rst low at 20-18 → all outputs 0 asynchronously, without waiting for a clock edge.
